// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding, default sizing and the 4:1 mux primitive.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 5;

  // 4:1 mux: d[sel] with d[3] selected by sel=2'b11.
  function automatic logic mux4(input logic [1:0] sel, input logic [3:0] d);
    return d[sel];
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two 4:1 muxes selected by {x,y}.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module serial_fa_cell
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Data order is {sel=11, sel=10, sel=01, sel=00}.
  assign s  = mux4({x, y}, {ci, ~ci, ~ci, ci});
  assign co = mux4({x, y}, {1'b1, ci, ci, 1'b0});

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving one full-adder cell LSB first.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is only accepted in IDLE; ignored while busy or done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;

  serial_fa_cell u_fa (
    .x  (opa[0]),
    .y  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so the result lands aligned after WIDTH shifts.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random stimulus for serial_adder, checked against a+b+cin.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One add; optionally pulses a competing start during busy cycle 'glitch'.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input int glitch, input string tag);
    logic [8:0] exp;
    int         nbusy;
    int         overlap;
    exp = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0; overlap = 0;
    for (int i = 1; i <= 8; i++) begin
      if (busy) nbusy++;
      if (done) overlap++;
      if (i == glitch) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, " early_done"}, 32'(overlap), 32'd0);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(exp[7:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[8]));
    tick();
    check({tag, " done_drop"}, 32'(done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " sum_hold"}, 32'(sum), 32'(exp[7:0]));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [7:0] qa[3], qb[3];
    logic       qc[3];
    logic [8:0] qexp[3];
    int         nacc, ndone, last_done, nseen, after_done;
    logic       prev_busy;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state and quiet idle
    tick(); tick();
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);
    check("idle sum", 32'(sum), 32'd0);
    check("idle cout", 32'(cout), 32'd0);

    // Directed arithmetic cases
    run_add(8'h0F, 8'h01, 1'b0, 0, "add_0f_01");
    run_add(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    run_add(8'hFF, 8'hFF, 1'b1, 0, "add_ff_ff_c");
    run_add(8'h00, 8'h00, 1'b0, 0, "add_zero");

    // Start during busy must be ignored
    run_add(8'h12, 8'h34, 1'b0, 3, "ignore_start");

    // Reset mid-add discards the work
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    check("midrst cout", 32'(cout), 32'd0);
    nseen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nseen++;
      tick();
    end
    check("midrst no_done", 32'(nseen), 32'd0);
    run_add(8'h80, 8'h80, 1'b0, 0, "after_rst");

    // Random adds against the arithmetic model
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_add(ra, rb, rc, int'($urandom_range(0, 8)), "rand");
    end

    // Start held high across three adds
    for (int i = 0; i < 3; i++) begin
      qa[i] = 8'($urandom_range(0, 255));
      qb[i] = 8'($urandom_range(0, 255));
      qc[i] = 1'($urandom_range(0, 1));
      qexp[i] = {1'b0, qa[i]} + {1'b0, qb[i]} + {8'd0, qc[i]};
    end
    a = qa[0]; b = qb[0]; cin = qc[0]; start = 1'b1;
    nacc = 0; ndone = 0; last_done = 0; after_done = 0; prev_busy = 1'b0;
    for (int cyc = 1; cyc <= 45 && ndone < 3; cyc++) begin
      tick();
      if (after_done != 0) begin
        check("b2b no_accept_in_done", 32'(busy), 32'd0);
        after_done = 0;
      end
      if (busy && done) check("b2b busy_and_done", 32'd1, 32'd0);
      if (busy && !prev_busy) begin
        nacc++;
        if (nacc < 3) begin
          a = qa[nacc]; b = qb[nacc]; cin = qc[nacc];
        end
      end
      if (done) begin
        check("b2b sum", 32'(sum), 32'(qexp[ndone][7:0]));
        check("b2b cout", 32'(cout), 32'(qexp[ndone][8]));
        if (ndone > 0) check("b2b spacing", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        ndone++;
        after_done = 1;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b done_count", 32'(ndone), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
